// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO, a fractional baud generator and configurable framing.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits (odd when PARITY_ODD=1).
module uart_tx_fifo #(
    parameter int CLK_HZ     = 9600000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_i,
    input  logic                          uart_wr_i,
    input  logic [DATA_BITS-1:0]          uart_dat_i,
    output logic                          uart_full,
    output logic [$clog2(FIFO_DEPTH):0]   uart_level,
    output logic                          uart_busy,
    output logic                          uart_ovf,
    input  logic                          uart_ovf_clr_i,
    output logic                          uart_tx
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int ACC_W = $clog2(CLK_HZ + BAUD) + 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [ACC_W-1:0] ACC_BAUD  = ACC_W'(BAUD);
    localparam logic [ACC_W-1:0] ACC_CLK   = ACC_W'(CLK_HZ);

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    localparam logic PARITY_ODD_UNUSED = (PARITY_ODD != 0);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [ACC_W-1:0]     acc_q, acc_d, acc_nxt;
    logic                 tick;
    logic                 tx_q, tx_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 fifo_full, push, pop;

    // Full is taken from the registered count, so a pop in the same cycle never frees a slot.
    always_comb begin
        fifo_full = (count_q == LW'(FIFO_DEPTH));
        push      = uart_wr_i & ~fifo_full;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        ovf_d = ovf_q & ~uart_ovf_clr_i;
        if (uart_wr_i && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        pop     = 1'b0;
        tick    = 1'b0;
        acc_nxt = acc_q + ACC_BAUD;
        acc_d   = acc_nxt;
        // The accumulator keeps the remainder, so bit edges never drift within a frame.
        if (state_q == S_IDLE) begin
            acc_d = '0;
        end else if (acc_nxt >= ACC_CLK) begin
            tick  = 1'b1;
            acc_d = acc_nxt - ACC_CLK;
        end

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    acc_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (stop_q == LAST_STOP) begin
                        acc_d = '0;
                        // Next byte starts straight out of the stop bit, no idle gap.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = (^shift_d) ^ PAR_ODD;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            acc_q    <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            acc_q    <= acc_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= uart_dat_i;
        end
    end

    assign uart_full  = fifo_full;
    assign uart_level = count_q;
    assign uart_busy  = (state_q != S_IDLE) | (count_q != '0);
    assign uart_ovf   = ovf_q;
    assign uart_tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (1200 baud depth 4, defaults, 7-bit two-stop depth 2)
// checked against a frame decoder and expected-byte queues.
module tb_uart_tx_fifo;

    localparam int CLK_A   = 9600;
    localparam int BAUD_A  = 1200;
    localparam int BIT_A   = CLK_A / BAUD_A;
    localparam int DEPTH_A = 4;
    localparam int CLK_B   = 9600000;
    localparam int BAUD_B  = 115200;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NB_A = 1 + 8 + PAR_BITS + 1;
    localparam int NB_C = 1 + 7 + PAR_BITS + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic       wr_a = 1'b0, clr_a = 1'b0, full_a, busy_a, ovf_a, tx_a;
    logic [7:0] dat_a = '0;
    logic [2:0] level_a;
    logic       wr_b = 1'b0, clr_b = 1'b0, full_b, busy_b, ovf_b, tx_b;
    logic [7:0] dat_b = '0;
    logic [4:0] level_b;
    logic       wr_c = 1'b0, clr_c = 1'b0, full_c, busy_c, ovf_c, tx_c;
    logic [6:0] dat_c = '0;
    logic [1:0] level_c;

    logic [8:0] exp_a_q[$];
    logic [8:0] exp_c_q[$];

    uart_tx_fifo #(.CLK_HZ(CLK_A), .BAUD(BAUD_A), .DATA_BITS(8), .STOP_BITS(1),
                   .FIFO_DEPTH(DEPTH_A), .PARITY_ODD(0)) u_dut_a (
        .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr_a), .uart_dat_i(dat_a),
        .uart_full(full_a), .uart_level(level_a), .uart_busy(busy_a), .uart_ovf(ovf_a),
        .uart_ovf_clr_i(clr_a), .uart_tx(tx_a));

    uart_tx_fifo u_dut_b (
        .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr_b), .uart_dat_i(dat_b),
        .uart_full(full_b), .uart_level(level_b), .uart_busy(busy_b), .uart_ovf(ovf_b),
        .uart_ovf_clr_i(clr_b), .uart_tx(tx_b));

    uart_tx_fifo #(.CLK_HZ(CLK_A), .BAUD(BAUD_A), .DATA_BITS(7), .STOP_BITS(2),
                   .FIFO_DEPTH(2), .PARITY_ODD(1)) u_dut_c (
        .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr_c), .uart_dat_i(dat_c),
        .uart_full(full_c), .uart_level(level_c), .uart_busy(busy_c), .uart_ovf(ovf_c),
        .uart_ovf_clr_i(clr_c), .uart_tx(tx_c));

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic line_of(input int sel);
        return (sel == 0) ? tx_a : tx_c;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_a : busy_c;
    endfunction

    // Cycle at which bit m of a default-config frame ends, counted from the start-bit fall.
    function automatic int bound_b(input int m);
        longint num;
        num = longint'(m) * CLK_B + BAUD_B - 1;
        return int'(num / BAUD_B);
    endfunction

    // Decode one frame from instance A (sel 0) or C (sel 1), checking each bit lasts BIT_A cycles.
    task automatic rx_frame(input int sel, input int nd, input int nstop, input int par_odd,
                            output int start_cyc, output logic par_bit, output logic busy_last);
        int         n;
        int         nbits;
        logic       v;
        logic [15:0] bits;
        logic [8:0] data;
        logic [8:0] exp;
        logic       exp_par;
        bit         hold_bad;
        bit         stop_bad;
        n = 0;
        hold_bad = 0;
        stop_bad = 0;
        bits = '1;
        data = '0;
        exp = '0;
        start_cyc = -1;
        par_bit = 1'bx;
        busy_last = 1'bx;
        while (line_of(sel) !== 1'b0 && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (line_of(sel) !== 1'b0) begin
            errors++;
            $display("FAIL rx_start dut=%0d: tx=%b, expected a start bit (0) within 3000 cycles", sel, line_of(sel));
            return;
        end
        start_cyc = cyc;
        nbits = 1 + nd + PAR_BITS + nstop;
        for (int b = 0; b < nbits; b++) begin
            v = line_of(sel);
            bits[b] = v;
            for (int k = 0; k < BIT_A; k++) begin
                if (line_of(sel) !== v) hold_bad = 1;
                if (b == nbits - 1 && k == BIT_A - 1) busy_last = busy_of(sel);
                step();
            end
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL rx_bit_hold dut=%0d: a bit changed inside its period, expected %0d stable cycles per bit", sel, BIT_A);
        end
        for (int i = 0; i < nstop; i++) begin
            if (bits[1 + nd + PAR_BITS + i] !== 1'b1) stop_bad = 1;
        end
        checks++;
        if (stop_bad) begin
            errors++;
            $display("FAIL rx_stop dut=%0d: stop bits %b, expected all 1", sel, bits >> (1 + nd + PAR_BITS));
        end
        for (int i = 0; i < nd; i++) data[i] = bits[1 + i];
        checks++;
        if (sel == 0 && exp_a_q.size() != 0) begin
            exp = exp_a_q.pop_front();
        end else if (sel != 0 && exp_c_q.size() != 0) begin
            exp = exp_c_q.pop_front();
        end else begin
            errors++;
            $display("FAIL rx_unexpected dut=%0d: got frame 0x%0h, expected no frame", sel, data);
            return;
        end
        if (data !== exp) begin
            errors++;
            $display("FAIL rx_data dut=%0d: got 0x%0h, expected 0x%0h", sel, data, exp);
        end
        exp_par = par_odd[0];
        for (int i = 0; i < nd; i++) exp_par = exp_par ^ exp[i];
`ifdef UART_TX_PARITY_EN
        par_bit = bits[1 + nd];
        checks++;
        if (par_bit !== exp_par) begin
            errors++;
            $display("FAIL rx_parity dut=%0d: got %b, expected %b for data 0x%0h", sel, par_bit, exp_par, exp);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({tx_a, full_a, level_a, busy_a, ovf_a} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: tx/full/level/busy/ovf = %b/%b/%0d/%b/%b, expected 1/0/0/0/0",
                     tx_a, full_a, level_a, busy_a, ovf_a);
        end
        checks++;
        if ({tx_b, full_b, level_b, busy_b, ovf_b} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: tx/full/level/busy/ovf = %b/%b/%0d/%b/%b, expected 1/0/0/0/0",
                     tx_b, full_b, level_b, busy_b, ovf_b);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_frame();
        int t0, s;
        logic p, bl;
        t0 = cyc;
        dat_a = 8'hA5;
        wr_a = 1'b1;
        exp_a_q.push_back(9'h0A5);
        step();
        wr_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || level_a !== 3'd1) begin
            errors++;
            $display("FAIL write_flags: busy=%b level=%0d, expected busy=1 level=1", busy_a, level_a);
        end
        rx_frame(0, 8, 1, 0, s, p, bl);
        checks++;
        if (s - t0 !== 2) begin
            errors++;
            $display("FAIL start_latency: start bit %0d cycles after write, expected 2", s - t0);
        end
        checks++;
        if (bl !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: busy in last stop cycle=%b after=%b, expected 1 then 0 (%0d-cycle frame)",
                     bl, busy_a, NB_A * BIT_A);
        end
    endtask

    task automatic test_back_to_back();
        int s1, s2;
        logic p, bl;
        dat_a = 8'h55;
        wr_a = 1'b1;
        exp_a_q.push_back(9'h055);
        step();
        dat_a = 8'h0F;
        exp_a_q.push_back(9'h00F);
        step();
        wr_a = 1'b0;
        rx_frame(0, 8, 1, 0, s1, p, bl);
        rx_frame(0, 8, 1, 0, s2, p, bl);
        checks++;
        if (s2 - s1 !== NB_A * BIT_A) begin
            errors++;
            $display("FAIL back_to_back_gap: second start %0d cycles after first, expected %0d", s2 - s1, NB_A * BIT_A);
        end
        checks++;
        if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_idle: busy=%b tx=%b, expected 0 and 1", busy_a, tx_a);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [9];
        bit idle_bad;
        vals = '{8'h31, 8'hC2, 8'h07, 8'hF0, 8'h9B, 8'h66, 8'hAA, 8'h00, 8'h00};
        idle_bad = 0;
        fork
            begin
                for (int i = 0; i <= 8; i++) begin
                    if (i == 1) begin
                        checks++;
                        if (level_a !== 3'd1) begin
                            errors++;
                            $display("FAIL ovf_level1: level=%0d, expected 1", level_a);
                        end
                    end
                    if (i == 4) begin
                        checks++;
                        if ({full_a, level_a} !== {1'b0, 3'd3}) begin
                            errors++;
                            $display("FAIL ovf_prefull: full=%b level=%0d, expected 0 and 3", full_a, level_a);
                        end
                    end
                    if (i == 5) begin
                        checks++;
                        if ({full_a, level_a, ovf_a} !== {1'b1, 3'd4, 1'b0}) begin
                            errors++;
                            $display("FAIL ovf_full: full=%b level=%0d ovf=%b, expected 1, 4, 0", full_a, level_a, ovf_a);
                        end
                    end
                    if (i == 6 || i == 7) begin
                        checks++;
                        if (ovf_a !== 1'b1) begin
                            errors++;
                            $display("FAIL ovf_set cycle %0d: ovf=%b, expected 1", i, ovf_a);
                        end
                    end
                    if (i == 8) begin
                        checks++;
                        if (ovf_a !== 1'b0) begin
                            errors++;
                            $display("FAIL ovf_clear: ovf=%b, expected 0", ovf_a);
                        end
                    end
                    wr_a = (i <= 6);
                    dat_a = vals[i];
                    clr_a = (i == 6 || i == 7);
                    if (i < DEPTH_A + 1) exp_a_q.push_back({1'b0, vals[i]});
                    step();
                end
                wr_a = 1'b0;
                clr_a = 1'b0;
            end
            begin
                int s;
                logic p, bl;
                repeat (DEPTH_A + 1) rx_frame(0, 8, 1, 0, s, p, bl);
            end
        join
        repeat (100) begin
            if (tx_a !== 1'b1 || busy_a !== 1'b0) idle_bad = 1;
            step();
        end
        checks++;
        if (idle_bad || exp_a_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_frame_count: extra activity=%0d pending=%0d, expected exactly %0d frames",
                     idle_bad, exp_a_q.size(), DEPTH_A + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0, s;
        logic p, bl;
        bit idle_bad;
        idle_bad = 0;
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            wr_a = 1'b1;
            dat_a = 8'(i * 8'h11);
            step();
        end
        wr_a = 1'b0;
        while (cyc < t0 + 20) step();
        checks++;
        if (tx_a !== 1'b0 || level_a !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset: tx=%b level=%0d, expected data bit 0 and level 3", tx_a, level_a);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({tx_a, level_a, busy_a, full_a} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: tx/level/busy/full = %b/%0d/%b/%b, expected 1/0/0/0",
                     tx_a, level_a, busy_a, full_a);
        end
        repeat (200) begin
            if (tx_a !== 1'b1 || busy_a !== 1'b0) idle_bad = 1;
            step();
        end
        checks++;
        if (idle_bad) begin
            errors++;
            $display("FAIL post_reset_idle: line or busy active after reset, expected idle");
        end
        t0 = cyc;
        dat_a = 8'hC3;
        wr_a = 1'b1;
        exp_a_q.push_back(9'h0C3);
        step();
        wr_a = 1'b0;
        rx_frame(0, 8, 1, 0, s, p, bl);
        checks++;
        if (s - t0 !== 2) begin
            errors++;
            $display("FAIL post_reset_latency: start %0d cycles after write, expected 2", s - t0);
        end
    endtask

    task automatic test_fractional_baud();
        int t0, s, n, st, len;
        logic v;
        bit stop_bad;
        stop_bad = 0;
        t0 = cyc;
        dat_b = 8'h00;
        wr_b = 1'b1;
        step();
        wr_b = 1'b0;
        n = 0;
        while (tx_b !== 1'b0 && n < 100) begin step(); n++; end
        s = cyc;
        checks++;
        if (tx_b !== 1'b0 || s - t0 !== 2) begin
            errors++;
            $display("FAIL baud_start: tx=%b after %0d cycles, expected 0 after 2", tx_b, s - t0);
        end
        n = 0;
        while (tx_b === 1'b0 && n < 2000) begin step(); n++; end
        checks++;
        if (cyc - s !== bound_b(9)) begin
            errors++;
            $display("FAIL baud_low_run: start+data low for %0d cycles, expected %0d", cyc - s, bound_b(9));
        end
        n = 0;
        while (busy_b === 1'b1 && n < 2000) begin
            if (tx_b !== 1'b1) stop_bad = 1;
            step();
            n++;
        end
        checks++;
        if (stop_bad || cyc - s !== bound_b(10)) begin
            errors++;
            $display("FAIL baud_frame_len: frame %0d cycles (stop glitch=%0d), expected %0d",
                     cyc - s, stop_bad, bound_b(10));
        end
        dat_b = 8'h55;
        wr_b = 1'b1;
        step();
        wr_b = 1'b0;
        n = 0;
        while (tx_b !== 1'b0 && n < 100) begin step(); n++; end
        s = cyc;
        for (int m = 1; m <= 9; m++) begin
            v = tx_b;
            st = cyc;
            n = 0;
            while (tx_b === v && n < 200) begin step(); n++; end
            len = cyc - st;
            checks++;
            if (len !== bound_b(m) - bound_b(m - 1)) begin
                errors++;
                $display("FAIL baud_bit%0d: lasted %0d cycles, expected %0d", m, len, bound_b(m) - bound_b(m - 1));
            end
        end
        n = 0;
        while (busy_b === 1'b1 && n < 200) begin step(); n++; end
        checks++;
        if (cyc - s !== bound_b(10)) begin
            errors++;
            $display("FAIL baud_frame_len_55: frame %0d cycles, expected %0d", cyc - s, bound_b(10));
        end
    endtask

    task automatic test_config_c();
        int s1, s2;
        logic p1, p2, bl;
        dat_c = 7'h07;
        wr_c = 1'b1;
        exp_c_q.push_back(9'h007);
        step();
        dat_c = 7'h5A;
        exp_c_q.push_back(9'h05A);
        step();
        wr_c = 1'b0;
        rx_frame(1, 7, 2, 1, s1, p1, bl);
        rx_frame(1, 7, 2, 1, s2, p2, bl);
        checks++;
        if (s2 - s1 !== NB_C * BIT_A || bl !== 1'b1 || busy_c !== 1'b0) begin
            errors++;
            $display("FAIL cfg_c_frame: spacing=%0d last busy=%b busy=%b, expected %0d, 1, 0",
                     s2 - s1, bl, busy_c, NB_C * BIT_A);
        end
`ifdef UART_TX_PARITY_EN
        checks++;
        if ({p1, p2} !== 2'b01) begin
            errors++;
            $display("FAIL cfg_c_odd_parity: bits %b%b, expected 01", p1, p2);
        end
`endif
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int s;
        logic p, bl;
        dat_a = 8'h07;
        wr_a = 1'b1;
        exp_a_q.push_back(9'h007);
        step();
        wr_a = 1'b0;
        rx_frame(0, 8, 1, 0, s, p, bl);
        checks++;
        if (p !== 1'b1 || bl !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL even_parity: parity=%b last busy=%b busy=%b, expected 1, 1, 0 (88-cycle frame)",
                     p, bl, busy_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_fractional_baud();
        test_config_c();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 / 115200 transmitter.
- Fractional baud generator derived from CLK_HZ and BAUD.
- Configurable data and stop bits, optional parity.
- FIFO_DEPTH-entry write FIFO so firmware-side logic can burst bytes.
- Sits between the readout/command logic and the board's serial TX pin, on the single system clock.

Parameters:
CLK_HZ, 9600000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; BAUD <= CLK_HZ/4
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
STOP_BITS, 1, stop bits per frame, legal 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of 2, >= 2
PARITY_ODD, 0, 1 = odd parity, 0 = even; used only when UART_TX_PARITY_EN is defined

Ports:
sys_clk_i  in  1  system clock
sys_rst_i  in  1  synchronous active-high reset
uart_wr_i  in  1  write strobe; one byte per cycle high
uart_dat_i  in  DATA_BITS  data to enqueue
uart_full  out  1  FIFO holds FIFO_DEPTH entries
uart_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy (excludes frame in shifter)
uart_busy  out  1  FIFO non-empty or frame in progress
uart_ovf  out  1  sticky: a write was dropped because FIFO full
uart_ovf_clr_i  in  1  clears uart_ovf
uart_tx  out  1  serial line, idle high

Behaviour:
- Reset (sys_rst_i high at posedge) takes effect at that edge, including mid-frame:
  - uart_tx=1, uart_full=0, uart_level=0, uart_busy=0, uart_ovf=0.
  - FIFO flushed, state IDLE, baud accumulator 0.
- FIFO write:
  - Accepted when uart_wr_i & ~uart_full.
  - uart_full is evaluated on the registered count. A write while full is dropped even if a pop occurs in the same cycle, and sets uart_ovf.
  - Set of uart_ovf wins over a simultaneous uart_ovf_clr_i.
  - Simultaneous accepted write and pop leaves uart_level unchanged.
- Flags: uart_level, uart_full and uart_busy are registered and update the cycle after the causing event.
- Baud tick:
  - ACC_W = $clog2(CLK_HZ+BAUD)+1.
  - acc is held at 0 in IDLE and cleared on every frame load.
  - In every other cycle: nxt = acc + BAUD. If nxt >= CLK_HZ then tick=1 and acc = nxt - CLK_HZ; else acc = nxt.
  - Each bit therefore lasts floor or ceil of CLK_HZ/BAUD clocks, with no cumulative drift within a frame.
- State machine:
  - IDLE:
    - uart_tx=1.
    - If FIFO non-empty: pop head into shifter, clear acc, go START.
    - uart_tx falls on the edge after the pop.
    - Latency: write at cycle N into an empty, idle block -> uart_tx low from cycle N+2.
  - START: uart_tx=0; on tick -> DATA with bit index 0.
  - DATA:
    - uart_tx = shifter[index].
    - On tick, index+1. After index DATA_BITS-1 -> PARITY if enabled, else STOP.
  - PARITY: see Optional Feature; on tick -> STOP.
  - STOP:
    - uart_tx=1; counts STOP_BITS ticks.
    - After the last stop tick: if FIFO non-empty, pop and go START in the same cycle (back-to-back, zero idle gap); else go IDLE.
- uart_busy = (state != IDLE) | (uart_level != 0).

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA, one bit period long.
  - Bit value = XOR of the data bits when PARITY_ODD=0; inverted XOR when PARITY_ODD=1.
  - Frame length = 1 + DATA_BITS + 1 + STOP_BITS bits.
- Undefined:
  - No PARITY state or parity logic; PARITY_ODD is ignored.
  - Frame length = 1 + DATA_BITS + STOP_BITS bits.

Test Plan:
1. CLK_HZ=9600, BAUD=1200, 8N1; write 0xA5 at cycle 0 -> uart_tx low cycles 2..9. Data 1,0,1,0,0,1,0,1, each held exactly 8 cycles. Stop high 8 cycles. uart_busy falls once the stop bit completes; 80-cycle frame.
2. Same config, write 0x55 then 0x0F on consecutive cycles -> two 80-cycle frames with the second start bit immediately after the first stop bit; uart_tx never idles between them.
3. FIFO_DEPTH=4, 6 writes on consecutive cycles from empty -> first 5 accepted (byte 0 popped at cycle 1), 6th dropped. uart_full=1 at cycle 5, uart_ovf=1 at cycle 6. Exactly 5 frames, bytes in order. uart_ovf_clr_i clears uart_ovf.
4. Defaults (9.6 MHz, 115200), write 0x00 -> every bit period 83 or 84 clocks. 10-bit frame is exactly 834 clocks from start-bit fall to end of stop bit.
5. Reset asserted during DATA of frame 1 with 3 bytes queued -> uart_tx=1 on the next edge, uart_level=0, uart_busy=0. No further frames until a new write.
6. UART_TX_PARITY_EN defined, 8E1, 1200 baud at 9600 Hz, write 0x07 -> parity bit 1, frame 88 cycles. With PARITY_ODD=1 -> parity bit 0.
